// File: rtl/dfa_equiv_monitor_if.sv
// Bundle for the dfa_equiv_monitor: configuration port, symbol stream and
// monitor outputs. The master side drives configuration and symbols; the
// slave side is the monitor.
//
// Handshake: sym_valid has no ready. A symbol presented with sym_valid=1 is
// consumed on that rising edge unless restart is also high. In that case the
// symbol is dropped. cfg_we and acc_we are single-cycle write strobes.
interface dfa_equiv_monitor_if #(
    parameter int STATE_W = 2,
    parameter int SYM_W   = 1,
    parameter int CNT_W   = 16
);
    logic                       cfg_we;
    logic                       cfg_sel;
    logic [STATE_W+SYM_W-1:0]   cfg_addr;
    logic [STATE_W-1:0]         cfg_data;
    logic                       acc_we;
    logic [(1<<STATE_W)-1:0]    acc_data;
    logic                       restart;
    logic                       sym_valid;
    logic [SYM_W-1:0]           sym;

    logic [STATE_W-1:0]         state_a;
    logic [STATE_W-1:0]         state_b;
    logic                       out_a;
    logic                       out_b;
    logic [CNT_W-1:0]           step_count;
    logic                       mismatch;
    logic [CNT_W-1:0]           mismatch_step;
    logic [SYM_W-1:0]           mismatch_sym;

    modport master (
        output cfg_we, cfg_sel, cfg_addr, cfg_data, acc_we, acc_data,
               restart, sym_valid, sym,
        input  state_a, state_b, out_a, out_b, step_count,
               mismatch, mismatch_step, mismatch_sym
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_addr, cfg_data, acc_we, acc_data,
               restart, sym_valid, sym,
        output state_a, state_b, out_a, out_b, step_count,
               mismatch, mismatch_step, mismatch_sym
    );
endinterface

// File: rtl/dfa_equiv_monitor.sv
// Lockstep equivalence monitor for two table-driven Moore automata sharing one
// symbol stream. Both automata start from START_STATE. The monitor records the
// step index and symbol of the first cycle where their accept outputs differ.
// The current automaton states are visible on state_a/state_b for debug.
module dfa_equiv_monitor #(
    parameter int STATE_W     = 2,
    parameter int SYM_W       = 1,
    parameter int START_STATE = 1,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    dfa_equiv_monitor_if.slave   bus
);
    localparam int NS     = 1 << STATE_W;
    localparam int ADDR_W = STATE_W + SYM_W;
    localparam int NE     = 1 << ADDR_W;
    localparam logic [STATE_W-1:0] START_S = STATE_W'(START_STATE);

    logic [STATE_W-1:0] tbl_a_q [NE];
    logic [STATE_W-1:0] tbl_b_q [NE];
    logic [NS-1:0]      acc_a_q, acc_b_q;

    logic [STATE_W-1:0] state_a_q, state_a_d;
    logic [STATE_W-1:0] state_b_q, state_b_d;
    logic [CNT_W-1:0]   step_q, step_d;
    logic               mm_q, mm_d;
    logic [CNT_W-1:0]   mm_step_q, mm_step_d;
    logic [SYM_W-1:0]   mm_sym_q, mm_sym_d;

    logic [STATE_W-1:0] next_a, next_b;
    logic [CNT_W-1:0]   step_inc;

    // Next states and the saturated step count, from pre-edge tables.
    assign next_a   = tbl_a_q[{state_a_q, bus.sym}];
    assign next_b   = tbl_b_q[{state_b_q, bus.sym}];
    assign step_inc = (step_q == {CNT_W{1'b1}}) ? step_q : step_q + 1'b1;

    // Configuration storage. Reset makes every entry a self-loop with no accepting states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NE; i++) begin
                tbl_a_q[i] <= STATE_W'(i >> SYM_W);
                tbl_b_q[i] <= STATE_W'(i >> SYM_W);
            end
            acc_a_q <= '0;
            acc_b_q <= '0;
        end else begin
            if (bus.cfg_we) begin
                if (bus.cfg_sel) tbl_b_q[bus.cfg_addr] <= bus.cfg_data;
                else             tbl_a_q[bus.cfg_addr] <= bus.cfg_data;
            end
            if (bus.acc_we) begin
                if (bus.cfg_sel) acc_b_q <= bus.acc_data;
                else             acc_a_q <= bus.acc_data;
            end
        end
    end

    // Step, restart and first-divergence capture. Restart takes priority over a symbol.
    always_comb begin
        state_a_d = state_a_q;
        state_b_d = state_b_q;
        step_d    = step_q;
        mm_d      = mm_q;
        mm_step_d = mm_step_q;
        mm_sym_d  = mm_sym_q;
        if (bus.restart) begin
            state_a_d = START_S;
            state_b_d = START_S;
            step_d    = '0;
            mm_d      = acc_a_q[START_S] != acc_b_q[START_S];
            mm_step_d = '0;
            mm_sym_d  = '0;
        end else if (bus.sym_valid) begin
            state_a_d = next_a;
            state_b_d = next_b;
            step_d    = step_inc;
            if (!mm_q && (acc_a_q[next_a] != acc_b_q[next_b])) begin
                mm_d      = 1'b1;
                mm_step_d = step_inc;
                mm_sym_d  = bus.sym;
            end
        end
    end

    // Register the automaton states, the counter and the capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_a_q <= START_S;
            state_b_q <= START_S;
            step_q    <= '0;
            mm_q      <= 1'b0;
            mm_step_q <= '0;
            mm_sym_q  <= '0;
        end else begin
            state_a_q <= state_a_d;
            state_b_q <= state_b_d;
            step_q    <= step_d;
            mm_q      <= mm_d;
            mm_step_q <= mm_step_d;
            mm_sym_q  <= mm_sym_d;
        end
    end

    assign bus.state_a       = state_a_q;
    assign bus.state_b       = state_b_q;
    assign bus.out_a         = acc_a_q[state_a_q];
    assign bus.out_b         = acc_b_q[state_b_q];
    assign bus.step_count    = step_q;
    assign bus.mismatch      = mm_q;
    assign bus.mismatch_step = mm_step_q;
    assign bus.mismatch_sym  = mm_sym_q;
endmodule

// File: doc/dfa_equiv_monitor.md
# dfa_equiv_monitor

Lockstep equivalence monitor for two runtime-programmable, table-driven deterministic automata (A and B) sharing one symbol stream. Each automaton is a parametrised Moore machine whose transition table and accept vector are loaded through a configuration port. On every step the block compares the two automata's accept outputs and captures the first divergence: step index and symbol. It is the simulation and silicon counterpart of the fixed two-state formal equality harness, used to cross-check candidate automata against a reference automaton.

## Interface
- STATE_W, 2, state register width; 2^STATE_W states per automaton
- SYM_W, 1, symbol width; alphabet size 2^SYM_W
- START_STATE, 1, start state index for both automata
- CNT_W, 16, width of the step counter and the captured step index
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_we  in  1  write one transition-table entry
- cfg_sel  in  1  target automaton: 0 = A, 1 = B (shared by cfg_we and acc_we)
- cfg_addr  in  STATE_W+SYM_W  entry address {state, symbol}
- cfg_data  in  STATE_W  next-state value
- acc_we  in  1  write the whole accept vector of the cfg_sel automaton
- acc_data  in  2^STATE_W  accept vector; bit s = state s accepting
- restart  in  1  synchronous return of both automata to START_STATE
- sym_valid  in  1  a symbol is presented this cycle; always consumed, no backpressure
- sym  in  SYM_W  symbol
- state_a, state_b  out  STATE_W  current states
- out_a, out_b  out  1  accept[state] of each automaton (combinational from registers)
- step_count  out  CNT_W  symbols consumed since reset or restart; saturating
- mismatch  out  1  sticky first-divergence flag
- mismatch_step  out  CNT_W  step index of the first divergence
- mismatch_sym  out  SYM_W  symbol consumed at the first divergence (0 if step 0)

## Operation
- Reset: state_a = state_b = START_STATE; every table entry = its own state (self-loop); both accept vectors = 0; step_count = 0; mismatch = 0; mismatch_step = 0; mismatch_sym = 0.
- Step (sym_valid=1, restart=0): state_x <= table_x[{state_x, sym}]; step_count increments and saturates at 2^CNT_W-1.
- Check on each step: compute na = accA[nextA] and nb = accB[nextB] from the pre-edge tables and accept vectors. If na != nb and mismatch = 0, set mismatch and capture mismatch_step = incremented step_count and mismatch_sym = sym.
- Later divergences are ignored until the flag is cleared.
- restart: both states <= START_STATE; step_count <= 0; mismatch is cleared. In the same cycle the block evaluates accA[START] != accB[START] using pre-edge accept vectors; if they differ, mismatch is set with mismatch_step = 0 and mismatch_sym = 0.
- restart together with sym_valid: restart wins and the symbol is dropped.
- Configuration writes:
  - A write takes effect at the clock edge.
  - A step in the same cycle as a write uses the pre-write contents, for both the transition and the check.
  - cfg_we and acc_we may be asserted together; both apply to cfg_sel.
- Configuration writes never clear mismatch or move the automata.

## Timing
- State, counter and capture registers update on the rising clk edge; reset acts immediately.
- out_a and out_b are valid in the same cycle as the state they reflect.
- mismatch rises on the edge that consumes the divergent symbol. Latency is 1 cycle from sym_valid.
- Consecutive symbols are accepted on every cycle; throughput is 1 symbol/clk.
- Reset mid-stream discards all table contents and the capture state.

## Test plan
- Reset values: assert reset -> state_a = state_b = 1, out_a = out_b = 0, step_count = 0, mismatch = 0.
- Equivalent run: load both automata with 1-0->1, 1-1->2, 2-0->1, 2-1->2 and accept = 4'b0100; restart; stream 0,1,1,0 -> out_a = out_b = 0,1,1,0, step_count = 4, mismatch = 0.
- Divergence: same setup, but B has 2-1->1; stream 1,1,0 -> mismatch set after step 2, mismatch_step = 2, mismatch_sym = 1. Flag and capture stay unchanged after step 3.
- Restart semantics: with accA = 4'b0010 and accB = 4'b0000, pulse restart together with sym_valid -> symbol dropped, step_count = 0, mismatch = 1, mismatch_step = 0.
- Write/step collision: in the same cycle, write A 1-1->3 and step with sym = 1 from state 1 -> state_a = 2 (old entry). Next sym = 1 from restart -> state_a = 3.
- Saturation: CNT_W = 4, 20 symbols -> step_count holds at 15. Reset mid-stream -> all outputs return to reset values.
